// File: rtl/tatsujin_pkg.sv
// tatsujin_pkg: colour constants, VGA coordinate widths and scheduler state encoding
package tatsujin_pkg;
   localparam int X_W = 8;
   localparam int Y_W = 7;
   localparam logic [2:0] COL_BLACK  = 3'b000;
   localparam logic [2:0] COL_RED    = 3'b100;
   localparam logic [2:0] COL_YELLOW = 3'b110;
   localparam logic [2:0] COL_WHITE  = 3'b111;
   typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd1, FINISH = 2'd2} sched_state_t;
endpackage

// File: rtl/note_lane_scheduler_square_scan.sv
// square_scan: dx-fastest raster counter over one SQ x SQ square
module square_scan #(
   parameter int SQ = 4
) (
   input  logic                                clk,
   input  logic                                clear,
   input  logic                                advance,
   output logic [(SQ > 1 ? $clog2(SQ) : 1)-1:0] dx,
   output logic [(SQ > 1 ? $clog2(SQ) : 1)-1:0] dy,
   output logic                                last
);
   localparam int W = SQ > 1 ? $clog2(SQ) : 1;
   assign last = (dx == W'(SQ - 1)) && (dy == W'(SQ - 1));
   always_ff @(posedge clk) begin
      if (clear) begin
         dx <= '0;
         dy <= '0;
      end else if (advance) begin
         dx <= dx + W'(1);
         if (dx == W'(SQ - 1)) dy <= dy + W'(1);
      end
   end
endmodule

// File: rtl/note_lane_scheduler.sv
// note_lane_scheduler: per-tick repaint of all note slots as SQ x SQ squares, one pixel per clock.
// NOTE_SCHED_MARKER_EN adds a white judgement-target square left of slot 0.
module note_lane_scheduler
   import tatsujin_pkg::*;
#(
   parameter int SLOTS = 10,
   parameter int SQ    = 4,
   parameter int X0    = 20,
   parameter int Y0    = 58,
   parameter int PITCH = 12
) (
   input  logic             CLOCK_50,
   input  logic             resetn,
   input  logic             tick,
   input  logic [SLOTS-1:0] red_seq,
   input  logic [SLOTS-1:0] yellow_seq,
   output logic [X_W-1:0]   x,
   output logic [Y_W-1:0]   y,
   output logic [2:0]       colour,
   output logic             plot,
   output logic             busy,
   output logic             done
);
`ifdef NOTE_SCHED_MARKER_EN
   localparam int MARK = 1;
`else
   localparam int MARK = 0;
`endif
   localparam int NS = SLOTS + MARK;
   localparam int SW = $clog2(NS + 1);
   localparam int QW = SQ > 1 ? $clog2(SQ) : 1;
   if (X0 + (SLOTS - 1) * PITCH + SQ - 1 > 159 || Y0 + SQ - 1 > 119 || (MARK == 1 && X0 < PITCH))
   begin : g_bad_geometry
      $fatal(1, "note_lane_scheduler: note lane does not fit the 160x120 frame");
   end
   sched_state_t     state;
   logic             pending, flush, sq_last, start, advance, marker;
   logic [SW-1:0]    slot;
   logic [SLOTS-1:0] red_s, yel_s, red_sh, yel_sh;
   logic [QW-1:0]    dx, dy;
   logic [X_W-1:0]   px;
   logic [Y_W-1:0]   py;
   logic [2:0]       pc;
   assign busy    = state != IDLE;
   assign done    = state == FINISH;
   assign start   = (tick && state == IDLE) || (state == FINISH && (pending || tick));
   assign advance = state == DRAW && !flush;
   square_scan #(.SQ(SQ)) u_scan (
      .clk     (CLOCK_50),
      .clear   (start),
      .advance (advance),
      .dx      (dx),
      .dy      (dy),
      .last    (sq_last)
   );
   always_comb begin
      red_sh = red_s >> slot;
      yel_sh = yel_s >> slot;
      marker = MARK == 1 && slot == SW'(SLOTS);
      px     = marker ? X_W'(X0 - PITCH + int'(dx)) : X_W'(X0 + int'(slot) * PITCH + int'(dx));
      py     = Y_W'(Y0 + int'(dy));
      pc     = marker ? COL_WHITE : red_sh[0] ? COL_RED : yel_sh[0] ? COL_YELLOW : COL_BLACK;
   end
   // flush spends one cycle after the last pixel so done trails the final plot by one cycle
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state   <= IDLE;
         pending <= 1'b0;
         flush   <= 1'b0;
         slot    <= '0;
         red_s   <= '0;
         yel_s   <= '0;
         x       <= '0;
         y       <= '0;
         colour  <= '0;
         plot    <= 1'b0;
      end else begin
         plot <= advance;
         if (advance) begin
            x      <= px;
            y      <= py;
            colour <= pc;
         end
         if (start) begin
            state <= DRAW;
            red_s <= red_seq;
            yel_s <= yellow_seq;
            slot  <= '0;
            flush <= 1'b0;
         end else if (state == DRAW) begin
            if (flush) state <= FINISH;
            else if (sq_last) begin
               slot  <= slot + SW'(1);
               flush <= slot == SW'(NS - 1);
            end
         end else if (state == FINISH) state <= IDLE;
         pending <= (state == FINISH) ? 1'b0 : (pending || (busy && tick));
      end
   end
endmodule

// File: tb/tb_note_lane_scheduler.sv
// tb_note_lane_scheduler: directed checks of pass timing, colours, pending ticks and mid-pass reset
module tb_note_lane_scheduler;
   logic       clk = 1'b0, resetn = 1'b0, tick = 1'b0;
   logic [9:0] red_seq = '0, yellow_seq = '0;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot, busy, done;
   int         errs = 0, checks = 0, cyc = 0, np = 0, nd = 0, tc = 0, dc = 0, d1 = 0;
   logic [7:0] lx [512];
   logic [6:0] ly [512];
   logic [2:0] lc [512];
   int         lcyc [512];
   always #5 clk = ~clk;
   note_lane_scheduler dut (
      .CLOCK_50   (clk),
      .resetn     (resetn),
      .tick       (tick),
      .red_seq    (red_seq),
      .yellow_seq (yellow_seq),
      .x          (x),
      .y          (y),
      .colour     (colour),
      .plot       (plot),
      .busy       (busy),
      .done       (done)
   );
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      #1;
      if (plot === 1'b1 && np < 512) begin
         lx[np]   = x;
         ly[np]   = y;
         lc[np]   = colour;
         lcyc[np] = cyc;
         np++;
      end
      if (done === 1'b1) nd++;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic pulse_tick;
      tick = 1'b1;
      tc   = cyc;
      @(negedge clk);
      tick = 1'b0;
   endtask
   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      dc = cyc;
      chk(tag, {31'd0, done}, 1);
   endtask
   function automatic int count_col(input int lo, input int hi, input logic [2:0] c);
      int k = 0;
      for (int i = lo; i <= hi; i++) if (lc[i] === c) k++;
      return k;
   endfunction
   initial begin
      int n;
      red_seq    = 10'h155;
      yellow_seq = 10'h2aa;
      tick       = 1'b1;
      repeat (3) @(negedge clk);
      tick = 1'b0;
      chk("rst_plot", {31'd0, plot}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_xyc", {14'd0, x, y, colour}, 0);
      resetn = 1'b1;
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 0);
      chk("idle_noplots", np, 0);
      // single red note in slot 0
      red_seq = 10'b0000000001; yellow_seq = '0; np = 0; nd = 0;
      pulse_tick;
      chk("a_busy_t1", {31'd0, busy}, 1);
      chk("a_plot_t1", {31'd0, plot}, 0);
      wait_done("a_done_seen", 300);
      chk("a_done_lat", dc - tc, 162);
      chk("a_busy_at_done", {31'd0, busy}, 1);
      @(negedge clk);
      chk("a_busy_after", {31'd0, busy}, 0);
      chk("a_done_after", {31'd0, done}, 0);
      chk("a_nplots", np, 160);
      chk("a_first_lat", lcyc[0] - tc, 2);
      chk("a_contig", lcyc[159] - lcyc[0], 159);
      chk("a_first_xy", {17'd0, lx[0], ly[0]}, {17'd0, 8'd20, 7'd58});
      chk("a_pix5_xy", {17'd0, lx[5], ly[5]}, {17'd0, 8'd21, 7'd59});
      chk("a_pix16_xy", {17'd0, lx[16], ly[16]}, {17'd0, 8'd32, 7'd58});
      chk("a_last_xy", {17'd0, lx[159], ly[159]}, {17'd0, 8'd131, 7'd61});
      chk("a_red_cnt", count_col(0, 15, 3'b100), 16);
      chk("a_black_cnt", count_col(16, 159, 3'b000), 144);
      // both bits in slot 9: red wins
      red_seq = 10'b1000000000; yellow_seq = 10'b1000000000; np = 0; nd = 0;
      pulse_tick;
      wait_done("b_done_seen", 300);
      @(negedge clk);
      chk("b_nplots", np, 160);
      chk("b_red_cnt", count_col(144, 159, 3'b100), 16);
      chk("b_yellow_none", count_col(0, 159, 3'b110), 0);
      chk("b_black_cnt", count_col(0, 143, 3'b000), 144);
      chk("b_s9_first_xy", {17'd0, lx[144], ly[144]}, {17'd0, 8'd128, 7'd58});
      chk("b_s9_last_xy", {17'd0, lx[159], ly[159]}, {17'd0, 8'd131, 7'd61});
      // yellow slot 1, input removed mid-pass
      red_seq = '0; yellow_seq = 10'b0000000010; np = 0; nd = 0;
      pulse_tick;
      repeat (10) @(negedge clk);
      yellow_seq = '0;
      wait_done("c_done_seen", 300);
      @(negedge clk);
      chk("c_yellow_cnt", count_col(16, 31, 3'b110), 16);
      chk("c_black_cnt", count_col(0, 159, 3'b000), 144);
      chk("c_s1_first_xy", {17'd0, lx[16], ly[16]}, {17'd0, 8'd32, 7'd58});
      chk("c_s1_last_xy", {17'd0, lx[31], ly[31]}, {17'd0, 8'd35, 7'd61});
      // three ticks during one pass give exactly one extra pass
      red_seq = 10'b0000000001; yellow_seq = '0; np = 0; nd = 0;
      pulse_tick;
      repeat (20) @(negedge clk);
      pulse_tick;
      repeat (30) @(negedge clk);
      pulse_tick;
      repeat (40) @(negedge clk);
      pulse_tick;
      wait_done("d_done1_seen", 300);
      d1 = dc;
      @(negedge clk);
      wait_done("d_done2_seen", 300);
      repeat (250) @(negedge clk);
      chk("d_ndone", nd, 2);
      chk("d_nplots", np, 320);
      chk("d_restart_lat", lcyc[160] - d1, 2);
      chk("d_pass2_red", count_col(160, 175, 3'b100), 16);
      // tick coincident with done
      np = 0; nd = 0;
      pulse_tick;
      wait_done("e_done1_seen", 300);
      d1 = dc;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      wait_done("e_done2_seen", 300);
      repeat (5) @(negedge clk);
      chk("e_ndone", nd, 2);
      chk("e_nplots", np, 320);
      chk("e_restart_lat", lcyc[160] - d1, 2);
      // reset at plot 50 aborts the pass
      np = 0; nd = 0;
      pulse_tick;
      n = 0;
      while (np < 50 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("f_reach50", np, 50);
      resetn = 1'b0;
      @(negedge clk);
      chk("f_rst_plot", {31'd0, plot}, 0);
      chk("f_rst_busy", {31'd0, busy}, 0);
      chk("f_rst_done", {31'd0, done}, 0);
      chk("f_rst_xyc", {14'd0, x, y, colour}, 0);
      resetn = 1'b1;
      repeat (200) @(negedge clk);
      chk("f_no_done", nd, 0);
      chk("f_no_more_plots", np, 50);
      np = 0;
      pulse_tick;
      wait_done("f_done_seen", 300);
      @(negedge clk);
      chk("f_full_pass", np, 160);
      chk("f_ndone", nd, 1);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
